id_ex_pipe: RTL and testbench

- ID/EX pipeline register directly upstream of the execute stage; its outputs feed the execute-stage op1/op2/inst inputs.
- Captures decoded instructions and register-file operands each cycle.
- Resolves RAW hazards by forwarding from EX, MEM and WB.
- Inserts a one-cycle bubble on load-use and honours downstream stall and branch flush.

---
 rtl/id_ex_pipe_pkg.sv | 42 ++++
 rtl/id_ex_pipe_fwd_mux.sv | 34 +++
 rtl/id_ex_pipe.sv | 117 +++++++++++
 tb/tb_id_ex_pipe.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pipe_pkg.sv
// Shared definitions for the ID/EX pipeline register slice.
//   - DATA_WIDTH / ZERO   : default datapath width and its zero value
//   - INST_*              : RV32 major opcodes the hazard logic cares about
//   - INST_NOP            : bubble instruction (addi x0,x0,0)
//   - src_use_t           : source register indices plus which of them the
//                           instruction actually reads
//   - decode_srcs()       : opcode -> source usage decode
package id_ex_pipe_pkg;

  localparam int                    DATA_WIDTH = 32;
  localparam logic [DATA_WIDTH-1:0] ZERO       = '0;

  localparam logic [6:0] INST_LOAD   = 7'b0000011;
  localparam logic [6:0] INST_LUI    = 7'b0110111;
  localparam logic [6:0] INST_AUIPC  = 7'b0010111;
  localparam logic [6:0] INST_JAL    = 7'b1101111;
  localparam logic [6:0] INST_STORE  = 7'b0100011;
  localparam logic [6:0] INST_BRANCH = 7'b1100011;
  localparam logic [6:0] INST_OP     = 7'b0110011;
  localparam logic [31:0] INST_NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_rs1;
    logic       use_rs2;
  } src_use_t;

  // rs1 is read by everything except the U-type and JAL formats; rs2 only by
  // R-type, stores and branches. Other encodings reuse those bits as immediate.
  function automatic src_use_t decode_srcs(input logic [31:0] inst);
    src_use_t s;
    s.rs1     = inst[19:15];
    s.rs2     = inst[24:20];
    s.use_rs1 = !(inst[6:0] == INST_LUI || inst[6:0] == INST_AUIPC ||
                  inst[6:0] == INST_JAL);
    s.use_rs2 = (inst[6:0] == INST_OP || inst[6:0] == INST_STORE ||
                 inst[6:0] == INST_BRANCH);
    return s;
  endfunction

endpackage

// File: rtl/id_ex_pipe_fwd_mux.sv
// Operand forwarding mux for one source register.
//   src_i                 : architectural source index
//   ex_en_i/ex_rd_i/...   : EX producer (enable already qualified by EX valid)
//   mem_we_i/mem_rd_i/... : MEM producer
//   wb_we_i/wb_rd_i/...   : WB producer
//   rf_data_i             : register-file read data
//   fwd_data_o            : selected operand, youngest producer wins
module id_ex_pipe_fwd_mux #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [4:0]            src_i,
  input  logic                  ex_en_i,
  input  logic [4:0]            ex_rd_i,
  input  logic [DATA_WIDTH-1:0] ex_data_i,
  input  logic                  mem_we_i,
  input  logic [4:0]            mem_rd_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  wb_we_i,
  input  logic [4:0]            wb_rd_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  input  logic [DATA_WIDTH-1:0] rf_data_i,
  output logic [DATA_WIDTH-1:0] fwd_data_o
);

  always_comb begin
    fwd_data_o = rf_data_i;
    // x0 is hardwired; a producer targeting x0 must never leak through.
    if (src_i == 5'd0)                         fwd_data_o = '0;
    else if (ex_en_i  && ex_rd_i  == src_i)    fwd_data_o = ex_data_i;
    else if (mem_we_i && mem_rd_i == src_i)    fwd_data_o = mem_data_i;
    else if (wb_we_i  && wb_rd_i  == src_i)    fwd_data_o = wb_data_i;
  end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register feeding the execute stage.
// Captures the decoded instruction with forwarded operands, inserts one
// bubble on a load-use hazard, holds on downstream stall and kills the slot
// on branch flush. Priority: reset > flush > stall > load-use > capture.
//   clk_i, rst_n_i        : clock, async active-low reset
//   id_*                  : decode-stage instruction and register reads
//   id_ready_o            : ID instruction consumed this cycle
//   stall_i, flush_i      : downstream hold / branch kill
//   ex_fwd_*, mem_fwd_*,
//   wb_fwd_*              : forwarding producers (EX rd comes from ex_inst_o)
//   ex_valid_o, ex_inst_o,
//   ex_op1_o, ex_op2_o    : EX slot contents
//   bubble_o              : high in the cycle a load-use bubble is inserted
module id_ex_pipe import id_ex_pipe_pkg::*; #(
  parameter int          DATA_WIDTH = id_ex_pipe_pkg::DATA_WIDTH,
  parameter logic [31:0] NOP_INST   = id_ex_pipe_pkg::INST_NOP
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  id_valid_i,
  input  logic [31:0]           id_inst_i,
  input  logic [DATA_WIDTH-1:0] id_rs1_data_i,
  input  logic [DATA_WIDTH-1:0] id_rs2_data_i,
  output logic                  id_ready_o,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  ex_fwd_we_i,
  input  logic [DATA_WIDTH-1:0] ex_fwd_data_i,
  input  logic                  mem_fwd_we_i,
  input  logic [4:0]            mem_fwd_rd_i,
  input  logic [DATA_WIDTH-1:0] mem_fwd_data_i,
  input  logic                  wb_fwd_we_i,
  input  logic [4:0]            wb_fwd_rd_i,
  input  logic [DATA_WIDTH-1:0] wb_fwd_data_i,
  output logic                  ex_valid_o,
  output logic [31:0]           ex_inst_o,
  output logic [DATA_WIDTH-1:0] ex_op1_o,
  output logic [DATA_WIDTH-1:0] ex_op2_o,
  output logic                  bubble_o
);

  localparam logic [DATA_WIDTH-1:0] OP_ZERO = DATA_WIDTH'(ZERO);

  src_use_t id_src;
  logic [4:0] ex_rd;
  logic       load_use;

  assign id_src = decode_srcs(id_inst_i);
  assign ex_rd  = ex_inst_o[11:7];

  // A load in EX has no data yet; one bubble moves it to MEM where the
  // MEM forwarding path carries the loaded value.
  assign load_use = ex_valid_o && (ex_inst_o[6:0] == INST_LOAD) &&
                    (ex_rd != 5'd0) && id_valid_i &&
                    ((id_src.use_rs1 && id_src.rs1 == ex_rd) ||
                     (id_src.use_rs2 && id_src.rs2 == ex_rd));

  // Flush consumes (and drops) the ID instruction even under stall.
  assign id_ready_o = rst_n_i && (flush_i || (!stall_i && !load_use));
  assign bubble_o   = rst_n_i && !flush_i && !stall_i && load_use;

  // Two identical forwarding muxes, index 0 = rs1, 1 = rs2.
  logic [1:0][4:0]            src_idx;
  logic [1:0][DATA_WIDTH-1:0] rf_data;
  logic [1:0][DATA_WIDTH-1:0] fwd_data;

  assign src_idx = {id_src.rs2, id_src.rs1};
  assign rf_data = {id_rs2_data_i, id_rs1_data_i};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    id_ex_pipe_fwd_mux #(.DATA_WIDTH(DATA_WIDTH)) u_fwd (
      .src_i      (src_idx[g]),
      .ex_en_i    (ex_valid_o && ex_fwd_we_i),
      .ex_rd_i    (ex_rd),
      .ex_data_i  (ex_fwd_data_i),
      .mem_we_i   (mem_fwd_we_i),
      .mem_rd_i   (mem_fwd_rd_i),
      .mem_data_i (mem_fwd_data_i),
      .wb_we_i    (wb_fwd_we_i),
      .wb_rd_i    (wb_fwd_rd_i),
      .wb_data_i  (wb_fwd_data_i),
      .rf_data_i  (rf_data[g]),
      .fwd_data_o (fwd_data[g])
    );
  end

  // Operands are sampled only on capture; a held slot never re-forwards.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_valid_o <= 1'b0;
      ex_inst_o  <= NOP_INST;
      ex_op1_o   <= OP_ZERO;
      ex_op2_o   <= OP_ZERO;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
      ex_inst_o  <= NOP_INST;
      ex_op1_o   <= OP_ZERO;
      ex_op2_o   <= OP_ZERO;
    end else if (stall_i) begin
      ex_valid_o <= ex_valid_o;
      ex_inst_o  <= ex_inst_o;
      ex_op1_o   <= ex_op1_o;
      ex_op2_o   <= ex_op2_o;
    end else if (load_use || !id_valid_i) begin
      ex_valid_o <= 1'b0;
      ex_inst_o  <= NOP_INST;
      ex_op1_o   <= OP_ZERO;
      ex_op2_o   <= OP_ZERO;
    end else begin
      ex_valid_o <= 1'b1;
      ex_inst_o  <= id_inst_i;
      ex_op1_o   <= fwd_data[0];
      ex_op2_o   <= fwd_data[1];
    end
  end

endmodule

// File: tb/tb_id_ex_pipe.sv
module tb_id_ex_pipe;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_rs1_data, id_rs2_data;
  logic        id_ready;
  logic        stall, flush;
  logic        ex_fwd_we;
  logic [31:0] ex_fwd_data;
  logic        mem_fwd_we;
  logic [4:0]  mem_fwd_rd;
  logic [31:0] mem_fwd_data;
  logic        wb_fwd_we;
  logic [4:0]  wb_fwd_rd;
  logic [31:0] wb_fwd_data;
  logic        ex_valid;
  logic [31:0] ex_inst, ex_op1, ex_op2;
  logic        bubble;

  id_ex_pipe dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .id_valid_i(id_valid), .id_inst_i(id_inst),
    .id_rs1_data_i(id_rs1_data), .id_rs2_data_i(id_rs2_data),
    .id_ready_o(id_ready), .stall_i(stall), .flush_i(flush),
    .ex_fwd_we_i(ex_fwd_we), .ex_fwd_data_i(ex_fwd_data),
    .mem_fwd_we_i(mem_fwd_we), .mem_fwd_rd_i(mem_fwd_rd), .mem_fwd_data_i(mem_fwd_data),
    .wb_fwd_we_i(wb_fwd_we), .wb_fwd_rd_i(wb_fwd_rd), .wb_fwd_data_i(wb_fwd_data),
    .ex_valid_o(ex_valid), .ex_inst_o(ex_inst),
    .ex_op1_o(ex_op1), .ex_op2_o(ex_op2), .bubble_o(bubble)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] op1;
    logic [31:0] op2;
    bit          chk_ops;
    string       tag;
  } exp_t;
  exp_t sb[$];

  function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] lw_op(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'h000, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_ex(input string tag, input logic v, input logic [31:0] inst,
                           input logic [31:0] op1, input logic [31:0] op2, input bit chk_ops);
    exp_t e;
    e.valid = v; e.inst = inst; e.op1 = op1; e.op2 = op2; e.chk_ops = chk_ops; e.tag = tag;
    sb.push_back(e);
  endtask

  // One clock edge, then compare the EX slot against the oldest expectation.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_empty: observed no expectation, expected one per edge");
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_valid"}, {31'b0, ex_valid}, {31'b0, e.valid});
      chk({e.tag, "_inst"}, ex_inst, e.inst);
      if (e.chk_ops) begin
        chk({e.tag, "_op1"}, ex_op1, e.op1);
        chk({e.tag, "_op2"}, ex_op2, e.op2);
      end
    end
  endtask

  task automatic chk_hs(input string tag, input logic rdy, input logic bub);
    #1;
    chk({tag, "_ready"}, {31'b0, id_ready}, {31'b0, rdy});
    chk({tag, "_bubble"}, {31'b0, bubble}, {31'b0, bub});
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; id_inst = NOP;
    id_rs1_data = '0; id_rs2_data = '0;
    stall = 1'b0; flush = 1'b0;
    ex_fwd_we = 1'b0; ex_fwd_data = '0;
    mem_fwd_we = 1'b0; mem_fwd_rd = '0; mem_fwd_data = '0;
    wb_fwd_we = 1'b0; wb_fwd_rd = '0; wb_fwd_data = '0;

    // Reset state
    #12;
    chk("rst_valid", {31'b0, ex_valid}, 32'd0);
    chk("rst_inst", ex_inst, NOP);
    chk("rst_op1", ex_op1, 32'd0);
    chk("rst_op2", ex_op2, 32'd0);
    chk("rst_bubble", {31'b0, bubble}, 32'd0);
    chk("rst_ready", {31'b0, id_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Plain capture: add x5,x1,x2 from the register file
    id_valid = 1'b1; id_inst = r_op(7'h00, 5'd5, 5'd1, 5'd2);
    id_rs1_data = 32'hA; id_rs2_data = 32'hB;
    chk_hs("cap", 1'b1, 1'b0);
    expect_ex("cap", 1'b1, r_op(7'h00, 5'd5, 5'd1, 5'd2), 32'hA, 32'hB, 1'b1);
    tick();

    // EX forward: sub x6,x5,x5 with EX producing x5
    id_inst = r_op(7'h20, 5'd6, 5'd5, 5'd5);
    id_rs1_data = 32'hDEAD; id_rs2_data = 32'hDEAD;
    ex_fwd_we = 1'b1; ex_fwd_data = 32'h11;
    chk_hs("exfwd", 1'b1, 1'b0);
    expect_ex("exfwd", 1'b1, r_op(7'h20, 5'd6, 5'd5, 5'd5), 32'h11, 32'h11, 1'b1);
    tick();

    // MEM beats WB; rs2 = x0 reads zero
    ex_fwd_we = 1'b0;
    mem_fwd_we = 1'b1; mem_fwd_rd = 5'd7; mem_fwd_data = 32'h22;
    wb_fwd_we = 1'b1; wb_fwd_rd = 5'd7; wb_fwd_data = 32'h33;
    id_inst = r_op(7'h00, 5'd10, 5'd7, 5'd0);
    expect_ex("memprio", 1'b1, r_op(7'h00, 5'd10, 5'd7, 5'd0), 32'h22, 32'h0, 1'b1);
    tick();

    // WB only on rs1; rs2 from register file
    mem_fwd_we = 1'b0;
    id_inst = r_op(7'h00, 5'd11, 5'd7, 5'd3); id_rs2_data = 32'h5;
    expect_ex("wbfwd", 1'b1, r_op(7'h00, 5'd11, 5'd7, 5'd3), 32'h33, 32'h5, 1'b1);
    tick();

    // x0 sources with every producer targeting x0
    ex_fwd_we = 1'b1; ex_fwd_data = 32'h99;
    mem_fwd_we = 1'b1; mem_fwd_rd = 5'd0;
    wb_fwd_we = 1'b1; wb_fwd_rd = 5'd0;
    id_inst = r_op(7'h00, 5'd12, 5'd0, 5'd0);
    id_rs1_data = 32'hDEAD; id_rs2_data = 32'hDEAD;
    expect_ex("x0", 1'b1, r_op(7'h00, 5'd12, 5'd0, 5'd0), 32'h0, 32'h0, 1'b1);
    tick();

    // Load into EX: lw x8,0(x1)
    ex_fwd_we = 1'b0; mem_fwd_we = 1'b0; wb_fwd_we = 1'b0;
    id_inst = lw_op(5'd8, 5'd1); id_rs1_data = 32'h100;
    expect_ex("lw", 1'b1, lw_op(5'd8, 5'd1), 32'h100, 32'h0, 1'b1);
    tick();

    // Load-use: add x9,x8,x1 stalls one cycle behind a bubble
    id_inst = r_op(7'h00, 5'd9, 5'd8, 5'd1);
    id_rs1_data = 32'hDEAD; id_rs2_data = 32'h7;
    chk_hs("lduse", 1'b0, 1'b1);
    expect_ex("lduse", 1'b0, NOP, 32'h0, 32'h0, 1'b0);
    tick();

    // Load now in MEM: capture with MEM forward
    mem_fwd_we = 1'b1; mem_fwd_rd = 5'd8; mem_fwd_data = 32'h44;
    chk_hs("ldfwd", 1'b1, 1'b0);
    expect_ex("ldfwd", 1'b1, r_op(7'h00, 5'd9, 5'd8, 5'd1), 32'h44, 32'h7, 1'b1);
    tick();

    // Stall three cycles with a new ID instruction and busy producers
    mem_fwd_we = 1'b0;
    stall = 1'b1;
    id_inst = r_op(7'h00, 5'd13, 5'd1, 5'd2);
    id_rs1_data = 32'hAA; id_rs2_data = 32'hBB;
    ex_fwd_we = 1'b1; ex_fwd_data = 32'h55;
    wb_fwd_we = 1'b1; wb_fwd_rd = 5'd8; wb_fwd_data = 32'h66;
    for (int i = 0; i < 3; i++) begin
      chk_hs("stall", 1'b0, 1'b0);
      expect_ex("stall", 1'b1, r_op(7'h00, 5'd9, 5'd8, 5'd1), 32'h44, 32'h7, 1'b1);
      tick();
    end
    stall = 1'b0; ex_fwd_we = 1'b0; wb_fwd_we = 1'b0;
    chk_hs("unstall", 1'b1, 1'b0);
    expect_ex("unstall", 1'b1, r_op(7'h00, 5'd13, 5'd1, 5'd2), 32'hAA, 32'hBB, 1'b1);
    tick();

    // Flush wins over a simultaneous stall
    flush = 1'b1; stall = 1'b1;
    id_inst = r_op(7'h00, 5'd14, 5'd1, 5'd2);
    chk_hs("flush", 1'b1, 1'b0);
    expect_ex("flush", 1'b0, NOP, 32'h0, 32'h0, 1'b1);
    tick();
    flush = 1'b0; stall = 1'b0;

    // No valid ID instruction loads a bubble
    id_valid = 1'b0;
    chk_hs("idle", 1'b1, 1'b0);
    expect_ex("idle", 1'b0, NOP, 32'h0, 32'h0, 1'b0);
    tick();

    // Refill, then assert reset between edges
    id_valid = 1'b1; id_inst = r_op(7'h00, 5'd15, 5'd1, 5'd2);
    id_rs1_data = 32'h77; id_rs2_data = 32'h88;
    expect_ex("refill", 1'b1, r_op(7'h00, 5'd15, 5'd1, 5'd2), 32'h77, 32'h88, 1'b1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, ex_valid}, 32'd0);
    chk("arst_inst", ex_inst, NOP);
    chk("arst_op1", ex_op1, 32'd0);
    chk("arst_ready", {31'b0, id_ready}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
